// File: rtl/juego_pkg.sv
// Shared constants for the hero-runner game: sequencer states, outcome codes
// and the obstacle type that marks a bonus.
package juego_pkg;

   typedef enum logic [2:0] {
      OFF  = 3'd0,
      WLCM = 3'd1,
      CH   = 3'd2,
      GAME = 3'd3,
      WL   = 3'd4,
      PA   = 3'd5
   } estado_t;

   localparam logic [1:0] WL_JUEGA  = 2'b00;
   localparam logic [1:0] WL_PIERDE = 2'b01;
   localparam logic [1:0] WL_GANA   = 2'b10;

   localparam int BONO_ID = 16;

endpackage

// File: rtl/control_juego_detector_flanco.sv
// Registered rising-edge detector: a one-cycle pulse per low-to-high
// transition on each bit; a held level never repeats.
module detector_flanco #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] sig_i,
   output logic [W-1:0] flanco_o
);

   logic [W-1:0] prev_q;
   logic [W-1:0] flanco_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q   <= '0;
         flanco_q <= '0;
      end else begin
         prev_q   <= sig_i;
         flanco_q <= sig_i & ~prev_q;
      end
   end

   assign flanco_o = flanco_q;

endmodule

// File: rtl/control_juego.sv
// Game sequencer: state register, lives, character select, invulnerability
// window, collision and bonus detection on each obstacle tick.
module control_juego #(
   parameter int WLCM_CYC  = 27_000_000,
   parameter int WL_CYC    = 135_000_000,
   parameter int VIDAS_INI = 3,
   parameter int NUM_PJ    = 3,
   parameter int INV_TICKS = 4,
   parameter int BONO_ID   = juego_pkg::BONO_ID
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_on,
   input  logic       btn_ok,
   input  logic       btn_pausa,
   input  logic       btn_izq,
   input  logic       btn_der,
   input  logic       clk_obstaculos,
   input  logic [6:0] obs_col,
   input  logic [6:0] heroe_seg,
   input  logic [4:0] tipo_obs,
   input  logic [1:0] mundo,
   output logic [2:0] presente,
   output logic [1:0] W_or_L,
   output logic       bono_tomado,
   output logic [1:0] personaje,
   output logic [1:0] vidas
);

   import juego_pkg::*;

   localparam int TW = $clog2(WL_CYC);
   localparam int IW = $clog2(INV_TICKS + 1);
   localparam logic [TW-1:0] WLCM_FIN = TW'(WLCM_CYC - 1);
   localparam logic [TW-1:0] WL_FIN   = TW'(WL_CYC - 1);
   localparam logic [TW-1:0] TIM_UNO  = TW'(1);
   localparam logic [IW-1:0] INV_INI  = IW'(INV_TICKS);
   localparam logic [IW-1:0] INV_UNO  = IW'(1);
   localparam logic [1:0]    PJ_MAX   = 2'(NUM_PJ - 1);
   localparam logic [1:0]    VID_INI  = 2'(VIDAS_INI);
   localparam logic [4:0]    BONO     = 5'(BONO_ID);

   estado_t       state_q, state_d;
   logic [1:0]    wl_q, wl_d;
   logic [1:0]    pj_q, pj_d;
   logic [1:0]    vidas_q, vidas_d;
   logic          bono_q, bono_d;
   logic [IW-1:0] inv_q, inv_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          obs_sync_q;

   logic [4:0] btn_e;
   logic       tick;
   logic       on_e, ok_e, pausa_e, izq_e, der_e;
   logic       choque, bono_ok;

   detector_flanco #(.W(5)) u_botones (
      .clk      (clk),
      .rst      (rst),
      .sig_i    ({btn_der, btn_izq, btn_pausa, btn_ok, btn_on}),
      .flanco_o (btn_e)
   );

   // First flop of the two-flop tick sample; the detector holds the second.
   always_ff @(posedge clk) begin
      if (rst) obs_sync_q <= 1'b0;
      else     obs_sync_q <= clk_obstaculos;
   end

   detector_flanco #(.W(1)) u_tick (
      .clk      (clk),
      .rst      (rst),
      .sig_i    (obs_sync_q),
      .flanco_o (tick)
   );

   assign {der_e, izq_e, pausa_e, ok_e, on_e} = btn_e;
   assign choque  = (obs_col & heroe_seg) != 7'd0;
   assign bono_ok = (tipo_obs == BONO) && (obs_col != 7'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OFF;
         wl_q    <= WL_JUEGA;
         pj_q    <= 2'd0;
         vidas_q <= 2'd0;
         bono_q  <= 1'b0;
         inv_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         wl_q    <= wl_d;
         pj_q    <= pj_d;
         vidas_q <= vidas_d;
         bono_q  <= bono_d;
         inv_q   <= inv_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wl_d    = wl_q;
      pj_d    = pj_q;
      vidas_d = vidas_q;
      inv_d   = inv_q;
      bono_d  = 1'b0;
      if (state_q != OFF && on_e) begin
         state_d = OFF;
         wl_d    = WL_JUEGA;
         pj_d    = 2'd0;
         vidas_d = 2'd0;
         inv_d   = '0;
      end else begin
         case (state_q)
            OFF:  if (on_e) state_d = WLCM;
            WLCM: if (timer_q == WLCM_FIN || ok_e) state_d = CH;
            CH: begin
               if (der_e)      pj_d = (pj_q == PJ_MAX) ? 2'd0 : pj_q + 2'd1;
               else if (izq_e) pj_d = (pj_q == 2'd0) ? PJ_MAX : pj_q - 2'd1;
               if (ok_e) begin
                  state_d = GAME;
                  vidas_d = VID_INI;
                  wl_d    = WL_JUEGA;
                  inv_d   = '0;
               end
            end
            GAME: begin
               if (mundo == 2'd3) begin
                  wl_d    = WL_GANA;
                  state_d = WL;
               end else if (pausa_e) begin
                  state_d = PA;
               end else if (tick) begin
                  if (inv_q != '0) inv_d = inv_q - INV_UNO;
                  // A hit reloads the window instead of decrementing it.
                  if (choque && inv_q == '0) begin
                     if (vidas_q == 2'd1) begin
                        vidas_d = 2'd0;
                        wl_d    = WL_PIERDE;
                        state_d = WL;
                     end else begin
                        vidas_d = vidas_q - 2'd1;
                        inv_d   = INV_INI;
                     end
                  end else if (bono_ok && !choque) begin
                     bono_d = 1'b1;
                  end
               end
            end
            PA: if (pausa_e) state_d = GAME;
            WL: begin
               if (timer_q == WL_FIN || ok_e) begin
                  state_d = WLCM;
                  wl_d    = WL_JUEGA;
                  vidas_d = 2'd0;
               end
            end
            default: state_d = OFF;
         endcase
      end
      timer_d = (state_d != state_q) ? '0 : timer_q + TIM_UNO;
   end

   assign presente    = state_q;
   assign W_or_L      = wl_q;
   assign bono_tomado = bono_q;
   assign personaje   = pj_q;
   assign vidas       = vidas_q;

endmodule
